// File: rtl/bm_pkg.sv
// ============================================================================
// Module   : bm_pkg
// Purpose  : Shared constants, types and sizing helpers for the block-matching
//            frame buffer (bank state codes, slice index type, depth math).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bm_pkg;

  // Bank-swap state codes
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  typedef logic [1:0] bank_state_t;

  // Wide enough for any realistic slice count, so an out-of-range slice
  // request can be compared against NUM_SLICES without losing bits.
  localparam int SLICE_IDX_W = 8;
  typedef logic [SLICE_IDX_W-1:0] slice_idx_t;

  // Number of write words needed to hold one slice of the given geometry.
  function automatic int wr_depth(input int width, input int height,
                                  input int bpp, input int wr_w);
    return (width * height * bpp) / wr_w;
  endfunction

  // Address width for a memory of the given depth (never below one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bm_bank_ctrl.sv
// ============================================================================
// Module   : bm_bank_ctrl
// Purpose  : Ping-pong bank-swap state machine. Tracks which physical bank is
//            exposed to the readers, whether it holds a complete frame, and
//            stalls the writer while the reader still owns its bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bm_bank_ctrl
  import bm_pkg::*;
(
  input  logic clk,
  input  logic reset,           // synchronous, active low
  input  logic frame_complete,  // accepted beat finishes the write bank
  input  logic rd_release,
  output logic wr_ready,
  output logic wr_frame_done,
  output logic rd_bank_valid,
  output logic rd_bank_sel,
  output logic swap             // high during the one-cycle swap state
);

  bank_state_t r_state;
  logic        r_done_pulse;
  logic        r_valid;
  logic        r_sel;

  // Bank-swap FSM with read-bank ownership tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_FILL;
      r_done_pulse <= 1'b0;
      r_valid      <= 1'b0;
      r_sel        <= 1'b0;
    end else begin
      r_done_pulse <= frame_complete;
      case (r_state)
        ST_FILL: begin
          if (frame_complete) begin
            // A release arriving with the completing beat frees the reader
            // bank immediately, so valid is held and the swap proceeds.
            r_state <= (!r_valid || rd_release) ? ST_SWAP : ST_WAIT;
          end else if (rd_release) begin
            r_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (rd_release) begin
            r_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_sel   <= ~r_sel;
          r_valid <= 1'b1;
          r_state <= ST_FILL;
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  assign wr_ready      = (r_state == ST_FILL);
  assign swap          = (r_state == ST_SWAP);
  assign wr_frame_done = r_done_pulse;
  assign rd_bank_valid = r_valid;
  assign rd_bank_sel   = r_sel;

endmodule

`default_nettype wire

// File: rtl/bram_wrapper.sv
// ============================================================================
// Module   : bram_wrapper
// Purpose  : Simple dual-port block RAM, one write port and one registered
//            read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_wrapper #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port plus one-cycle registered read
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/bm_frame_buffer.sv
// ============================================================================
// Module   : bm_frame_buffer
// Purpose  : Double-buffered slice frame store. Writes fill the hidden bank
//            with per-slice auto-incrementing addresses; readers access the
//            exposed bank through one port per slice. Inner slices are wider
//            by CENTER_MARGIN on each side.
//            Optional macro BM_FRAME_BUFFER_ERR_EN enables the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bm_frame_buffer
  import bm_pkg::*;
#(
  parameter int NUM_SLICES    = 3,
  parameter int SLICE_WIDTH   = 240,
  parameter int SLICE_HEIGHT  = 480,
  parameter int CENTER_MARGIN = 32,
  parameter int BITS_PER_PIX  = 2,
  parameter int WR_W          = 16,
  parameter int RD_W          = 8,
  localparam int WR_DEPTH_O = wr_depth(SLICE_WIDTH, SLICE_HEIGHT, BITS_PER_PIX, WR_W),
  localparam int WR_DEPTH_I = wr_depth(SLICE_WIDTH + 2 * CENTER_MARGIN, SLICE_HEIGHT,
                                       BITS_PER_PIX, WR_W),
  localparam int RATIO      = WR_W / RD_W,
  localparam int RD_AD_W    = addr_w(WR_DEPTH_I * RATIO)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic                                wr_sof,
  input  logic [$clog2(NUM_SLICES)-1:0]       wr_slice,
  input  logic [WR_W-1:0]                     wr_data,
  output logic                                wr_frame_done,
  input  logic [NUM_SLICES-1:0][RD_AD_W-1:0]  rd_addr,
  output logic [NUM_SLICES-1:0][RD_W-1:0]     rd_data,
  output logic                                rd_bank_valid,
  output logic                                rd_bank_sel,
  input  logic                                rd_release,
  output logic                                err
);

  localparam int WAW      = addr_w(WR_DEPTH_I);
  localparam int LANE_W   = addr_w(RATIO);
  // Read lanes are selected by the low address bits, so RATIO is a power of 2.
  localparam int LANE_SH  = (RATIO > 1) ? $clog2(RATIO) : 0;

  logic                  w_swap;
  logic                  w_accept;
  slice_idx_t            w_slice;
  logic                  w_in_range;
  logic                  w_hit_done;
  logic                  w_beat_ok;
  logic                  w_frame_complete;
  logic                  w_wr_bank;
  logic                  r_rd_sel;
  logic [NUM_SLICES-1:0] w_sel;
  logic [NUM_SLICES-1:0] w_at_last;
  logic [NUM_SLICES-1:0] w_done_next;
  logic [NUM_SLICES-1:0] r_done;
  logic [WAW-1:0]        r_cnt [NUM_SLICES];

  assign w_accept   = wr_valid && wr_ready;
  assign w_slice    = slice_idx_t'(wr_slice);
  assign w_in_range = (w_slice < slice_idx_t'(NUM_SLICES));
  assign w_hit_done = |(w_sel & r_done);
  // sof restarts the frame, so it is allowed even into a completed slice
  assign w_beat_ok  = w_accept && w_in_range && (wr_sof || !w_hit_done);
  assign w_wr_bank  = ~rd_bank_sel;

  assign w_done_next      = wr_sof ? (w_sel & w_at_last) : (r_done | (w_sel & w_at_last));
  assign w_frame_complete = w_beat_ok && (|(w_sel & w_at_last)) && (&w_done_next);

  bm_bank_ctrl u_bank_ctrl (
    .clk            (clk),
    .reset          (reset),
    .frame_complete (w_frame_complete),
    .rd_release     (rd_release),
    .wr_ready       (wr_ready),
    .wr_frame_done  (wr_frame_done),
    .rd_bank_valid  (rd_bank_valid),
    .rd_bank_sel    (rd_bank_sel),
    .swap           (w_swap)
  );

  // Per-slice write counters and done bits; the last address holds the counter
  always_ff @(posedge clk) begin
    if (!reset || w_swap) begin
      for (int s = 0; s < NUM_SLICES; s++) begin
        r_cnt[s] <= '0;
      end
      r_done <= '0;
    end else if (w_beat_ok) begin
      for (int s = 0; s < NUM_SLICES; s++) begin
        if (wr_sof) begin
          r_cnt[s] <= (w_sel[s] && !w_at_last[s]) ? WAW'(1) : '0;
        end else if (w_sel[s] && !w_at_last[s]) begin
          r_cnt[s] <= r_cnt[s] + 1'b1;
        end
      end
      r_done <= w_done_next;
    end
  end

  // Bank selection for the read mux follows the address by one cycle
  always_ff @(posedge clk) begin
    r_rd_sel <= rd_bank_sel;
  end

  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
    localparam int DEPTH = ((s == 0) || (s == NUM_SLICES - 1)) ? WR_DEPTH_O : WR_DEPTH_I;
    localparam int AW    = addr_w(DEPTH);

    logic [WAW-1:0]    w_waddr;
    logic [AW-1:0]     w_rword;
    logic [LANE_W-1:0] r_lane;
    logic [WR_W-1:0]   w_q [2];
    logic [WR_W-1:0]   w_qsel;
    logic [RD_W-1:0]   w_rd;

    assign w_sel[s]     = (w_slice == slice_idx_t'(s));
    assign w_waddr      = wr_sof ? '0 : r_cnt[s];
    assign w_at_last[s] = (w_waddr == WAW'(DEPTH - 1));
    assign w_rword      = AW'(rd_addr[s] >> LANE_SH);

    for (genvar b = 0; b < 2; b++) begin : g_bank
      bram_wrapper #(
        .DATA_W (WR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
      ) u_bram (
        .clk   (clk),
        .we    (w_beat_ok && w_sel[s] && (w_wr_bank == (b != 0))),
        .waddr (w_waddr[AW-1:0]),
        .wdata (wr_data),
        .raddr (w_rword),
        .rdata (w_q[b])
      );
    end

    // Lane of the wide word picked by the read address, aligned with the RAM output
    always_ff @(posedge clk) begin
      r_lane <= rd_addr[s][LANE_W-1:0];
    end

    assign w_qsel = r_rd_sel ? w_q[1] : w_q[0];

    // Narrow read lane mux, lowest lane first
    always_comb begin
      w_rd = w_qsel[RD_W-1:0];
      for (int l = 0; l < RATIO; l++) begin
        if (r_lane == LANE_W'(l)) begin
          w_rd = w_qsel[l*RD_W +: RD_W];
        end
      end
    end

    assign rd_data[s] = w_rd;
  end

`ifdef BM_FRAME_BUFFER_ERR_EN
  logic r_err;
  logic w_any_cnt;

  // Any slice has progressed, so an sof now abandons a partial frame
  always_comb begin
    w_any_cnt = 1'b0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (r_cnt[s] != '0) begin
        w_any_cnt = 1'b1;
      end
    end
  end

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if ((w_accept && (!w_in_range || (w_hit_done && !wr_sof) || (wr_sof && w_any_cnt)))
                 || (rd_release && !rd_bank_valid)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bm_frame_buffer.sv
// ============================================================================
// Module   : tb_bm_frame_buffer
// Purpose  : Self-checking bench for bm_frame_buffer with a frame-level model
//            (expected bank contents, bank ownership and error flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bm_frame_buffer;

`ifdef BM_FRAME_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic            wr_ready;
  logic            wr_sof;
  logic [1:0]      wr_slice;
  logic [15:0]     wr_data;
  logic            wr_frame_done;
  logic [2:0][3:0] rd_addr;
  logic [2:0][7:0] rd_data;
  logic            rd_bank_valid;
  logic            rd_bank_sel;
  logic            rd_release;
  logic            err;

  bm_frame_buffer #(
    .NUM_SLICES    (3),
    .SLICE_WIDTH   (16),
    .SLICE_HEIGHT  (2),
    .CENTER_MARGIN (8),
    .BITS_PER_PIX  (2),
    .WR_W          (16),
    .RD_W          (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_sof        (wr_sof),
    .wr_slice      (wr_slice),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_bank_valid (rd_bank_valid),
    .rd_bank_sel   (rd_bank_sel),
    .rd_release    (rd_release),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference state
  logic [15:0] frm     [3][8];
  logic [15:0] exp_mem [2][3][8];
  bit          exp_sel;
  bit          exp_valid;
  bit          exp_err;
  int          wd [3] = '{4, 8, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("ready_timeout", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic send_beat(input bit sof, input logic [1:0] sl, input logic [15:0] d);
    wait_ready();
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_slice = sl;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
  endtask

  task automatic gen_frame(input bit seq);
    int idx = 0;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 8; w++) begin
        frm[s][w] = seq ? 16'(idx) : 16'($urandom);
        if (w < wd[s]) idx++;
      end
  endtask

  // Sends a whole frame; random slice interleave and idle gaps unless seq
  task automatic send_frame(input bit seq, input bit rel_last);
    int order[$];
    int pos [3] = '{0, 0, 0};
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < wd[s]; w++) order.push_back(s);
    if (!seq) begin
      for (int i = order.size() - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
    end
    for (int i = 0; i < order.size(); i++) begin
      int s = order[i];
      if (!seq && $urandom_range(0, 3) == 0) step();
      if (i == order.size() - 1) rd_release = rel_last;
      send_beat(i == 0, 2'(s), frm[s][pos[s]]);
      rd_release = 1'b0;
      pos[s]++;
      if (i != order.size() - 1) check("no_early_done", {31'd0, wr_frame_done}, 32'd0);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 3; s++) rd_addr[s] = (a < 2 * wd[s]) ? 4'(a) : 4'd0;
      step();
      for (int s = 0; s < 3; s++)
        if (a < 2 * wd[s])
          check($sformatf("rd_s%0d_a%0d", s, a), {24'd0, rd_data[s]},
                {24'd0, 8'(exp_mem[exp_sel][s][a / 2] >> (8 * (a % 2)))});
    end
  endtask

  // Completing beat has just been clocked and the swap is immediate
  task automatic finish_swap();
    check("done_pulse", {31'd0, wr_frame_done}, 32'd1);
    check("ready_in_swap", {31'd0, wr_ready}, 32'd0);
    check("valid_in_swap", {31'd0, rd_bank_valid}, {31'd0, exp_valid});
    step();
    exp_sel   = ~exp_sel;
    exp_valid = 1'b1;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 8; w++) exp_mem[exp_sel][s][w] = frm[s][w];
    check("done_cleared", {31'd0, wr_frame_done}, 32'd0);
    check("ready_after_swap", {31'd0, wr_ready}, 32'd1);
    check("valid_after_swap", {31'd0, rd_bank_valid}, 32'd1);
    check("sel_after_swap", {31'd0, rd_bank_sel}, {31'd0, exp_sel});
    check("err", {31'd0, err}, {31'd0, exp_err});
    readback();
  endtask

  // mode 0: reader released beforehand; 1: reader holds (WAIT); 2: release with last beat
  task automatic run_frame(input int mode, input bit seq);
    gen_frame(seq);
    if (mode == 0 && exp_valid) begin
      pulse_release();
      exp_valid = 1'b0;
      check("release_drops_valid", {31'd0, rd_bank_valid}, 32'd0);
    end
    send_frame(seq, mode == 2);
    if (mode == 1 && exp_valid) begin
      check("done_pulse_wait", {31'd0, wr_frame_done}, 32'd1);
      // Writer pushes while stalled; nothing may be taken
      wr_valid = 1'b1; wr_sof = 1'b1; wr_slice = 2'd0; wr_data = 16'h5555;
      step();
      step();
      wr_valid = 1'b0; wr_sof = 1'b0;
      check("wait_ready_low", {31'd0, wr_ready}, 32'd0);
      check("wait_valid_held", {31'd0, rd_bank_valid}, 32'd1);
      check("wait_sel_held", {31'd0, rd_bank_sel}, {31'd0, exp_sel});
      pulse_release();
      check("release_ready_m1", {31'd0, wr_ready}, 32'd0);
      check("release_valid_m1", {31'd0, rd_bank_valid}, 32'd1);
      step();
      exp_sel = ~exp_sel;
      for (int s = 0; s < 3; s++)
        for (int w = 0; w < 8; w++) exp_mem[exp_sel][s][w] = frm[s][w];
      check("release_ready_m2", {31'd0, wr_ready}, 32'd1);
      check("release_valid_m2", {31'd0, rd_bank_valid}, 32'd1);
      check("release_sel_m2", {31'd0, rd_bank_sel}, {31'd0, exp_sel});
      readback();
    end else begin
      finish_swap();
    end
  endtask

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_slice = '0; wr_data = '0;
    rd_addr = '0; rd_release = 1'b0;
    exp_sel = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
    step(); step();
    reset = 1'b1;
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_done", {31'd0, wr_frame_done}, 32'd0);
    check("rst_valid", {31'd0, rd_bank_valid}, 32'd0);
    check("rst_sel", {31'd0, rd_bank_sel}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Basic fill with data = beat index, then slice-1 address 0
    run_frame(0, 1'b1);
    rd_addr[1] = 4'd0;
    step();
    check("slice1_addr0", {24'd0, rd_data[1]}, 32'h04);

    // Backpressure, then release coinciding with the completing beat
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);

    // Restart: partial slice 0 abandoned by a second sof
    gen_frame(1'b0);
    pulse_release();
    exp_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(i == 0, 2'd0, 16'($urandom));
    check("err_before_restart", {31'd0, err}, {31'd0, exp_err});
    frm[0][0] = 16'hAAAA;
    send_beat(1'b1, 2'd0, 16'hAAAA);
    if (ERR_EN) exp_err = 1'b1;
    for (int s = 0; s < 3; s++)
      for (int w = (s == 0) ? 1 : 0; w < wd[s]; w++) send_beat(1'b0, 2'(s), frm[s][w]);
    finish_swap();
    rd_addr[0] = 4'd0;
    step();
    check("restart_aa", {24'd0, rd_data[0]}, 32'hAA);

    // Release while nothing is valid is ignored
    pulse_release();
    exp_valid = 1'b0;
    pulse_release();
    if (ERR_EN) exp_err = 1'b1;
    check("idle_release_valid", {31'd0, rd_bank_valid}, 32'd0);
    check("idle_release_err", {31'd0, err}, {31'd0, exp_err});

    // Overflow into a done slice and an out-of-range slice are both dropped
    gen_frame(1'b0);
    for (int w = 0; w < 4; w++) send_beat(w == 0, 2'd0, frm[0][w]);
    send_beat(1'b0, 2'd0, 16'hDEAD);
    check("overflow_no_done", {31'd0, wr_frame_done}, 32'd0);
    send_beat(1'b0, 2'd3, 16'hBEEF);
    if (ERR_EN) exp_err = 1'b1;
    check("overflow_err", {31'd0, err}, {31'd0, exp_err});
    for (int s = 1; s < 3; s++)
      for (int w = 0; w < wd[s]; w++) send_beat(1'b0, 2'(s), frm[s][w]);
    finish_swap();

    // Reset while stalled in WAIT
    gen_frame(1'b0);
    send_frame(1'b0, 1'b0);
    check("pre_reset_wait", {31'd0, wr_ready}, 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_sel = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
    check("midwait_rst_ready", {31'd0, wr_ready}, 32'd1);
    check("midwait_rst_valid", {31'd0, rd_bank_valid}, 32'd0);
    check("midwait_rst_sel", {31'd0, rd_bank_sel}, 32'd0);
    check("midwait_rst_err", {31'd0, err}, 32'd0);

    // Random reader behaviour over a few more frames
    for (int f = 0; f < 4; f++) begin
      int mode = exp_valid ? $urandom_range(0, 2) : 0;
      run_frame(mode, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
